// File: rtl/delay_fb_if.sv
// Port bundle for the stereo feedback delay core.
//
// Handshake: sample_vld is a one-cycle strobe with no ready return. The core
// takes a sample only while busy is low; a strobe that arrives while busy is
// high is dropped and raises the sticky overrun flag. out_vld is a one-cycle
// strobe with no backpressure; left_out/right_out hold their value between
// strobes.
interface delay_fb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int COEF_W = 8
);
  logic                     sample_vld;
  logic signed [DATA_W-1:0] left_in;
  logic signed [DATA_W-1:0] right_in;
  logic [ADDR_W-1:0]        delay_len;
  logic [COEF_W-1:0]        fb_gain;
  logic [COEF_W-1:0]        mix_gain;
  logic [1:0]               mode;
  logic                     overrun_clr;
  logic signed [DATA_W-1:0] left_out;
  logic signed [DATA_W-1:0] right_out;
  logic                     out_vld;
  logic                     busy;
  logic                     overrun;
  // Current FSM state: 0 IDLE, 1 RD, 2 MUL, 3 SUM.
  logic [1:0]               dbg_state;

  // Sample source / control side.
  modport master (
    output sample_vld, left_in, right_in, delay_len, fb_gain, mix_gain,
           mode, overrun_clr,
    input  left_out, right_out, out_vld, busy, overrun, dbg_state
  );

  // Delay core side.
  modport slave (
    input  sample_vld, left_in, right_in, delay_len, fb_gain, mix_gain,
           mode, overrun_clr,
    output left_out, right_out, out_vld, busy, overrun, dbg_state
  );
endinterface

// File: rtl/delay_fb_core.sv
// Stereo digital delay with feedback, wet/dry mix and output saturation.
// One stereo sample is processed per accepted sample_vld through a four-state
// pipeline (IDLE, RD, MUL, SUM); each channel owns a circular buffer of
// 2**ADDR_W entries with a one-cycle registered read.
module delay_fb_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int COEF_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  delay_fb_if.slave io
);

  localparam int DEPTH = 1 << ADDR_W;
  // Sum width: two extra bits of headroom before saturation.
  localparam int SW = DATA_W + 2;
  // Scaled product width: gain < 1, so one extra bit covers every result.
  localparam int FW = DATA_W + 1;
  // Full product width of a signed sample times an unsigned gain.
  localparam int PW = DATA_W + COEF_W + 1;

  localparam logic [1:0] MODE_STEREO = 2'b00;
  localparam logic [1:0] MODE_MONO   = 2'b01;
  localparam logic [1:0] MODE_PING   = 2'b10;
  localparam logic [1:0] MODE_BYP    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_MUL  = 2'd2,
    S_SUM  = 2'd3
  } state_t;

  // Clamp a wide signed sum into the signed sample range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = SW'($signed({1'b0, {(DATA_W-1){1'b1}}}));
    lo = SW'($signed({1'b1, {(DATA_W-1){1'b0}}}));
    if (v > hi) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < lo) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = DATA_W'(v);
    end
  endfunction

  // tap * gain / 2**COEF_W with an arithmetic (floor) shift.
  function automatic logic signed [FW-1:0] scale(input logic signed [DATA_W-1:0] s,
                                                 input logic [COEF_W-1:0]        g);
    logic signed [PW-1:0] p;
    p = PW'(s) * PW'($signed({1'b0, g}));
    scale = FW'(p >>> COEF_W);
  endfunction

  // FSM and control
  state_t state_q, state_d;
  logic   accept;
  logic   rd_en;
  logic   ram_we;
  logic   drop;

  // Per-sample configuration and inputs captured on acceptance
  logic signed [DATA_W-1:0] lin_q, lin_d;
  logic signed [DATA_W-1:0] rin_q, rin_d;
  logic [ADDR_W-1:0]        dlen_q, dlen_d;
  logic [COEF_W-1:0]        fbg_q, fbg_d;
  logic [COEF_W-1:0]        mixg_q, mixg_d;
  logic [1:0]               mode_q, mode_d;

  // Buffer pointers
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] rd_addr;

  // Circular buffers and their registered read ports
  logic signed [DATA_W-1:0] mem_l [DEPTH];
  logic signed [DATA_W-1:0] mem_r [DEPTH];
  logic signed [DATA_W-1:0] rd_l_q;
  logic signed [DATA_W-1:0] rd_r_q;

  // Tap stage
  logic                     tap_ok;
  logic signed [DATA_W-1:0] tap_l;
  logic signed [DATA_W-1:0] tap_r;
  logic signed [FW-1:0]     fb_l_q, fb_l_d;
  logic signed [FW-1:0]     fb_r_q, fb_r_d;
  logic signed [FW-1:0]     wet_l_q, wet_l_d;
  logic signed [FW-1:0]     wet_r_q, wet_r_d;

  // Sum stage
  logic signed [FW-1:0]     mono_sum;
  logic signed [DATA_W-1:0] dry_l;
  logic signed [DATA_W-1:0] dry_r;
  logic signed [DATA_W-1:0] wr_l;
  logic signed [DATA_W-1:0] wr_r;
  logic signed [DATA_W-1:0] out_l;
  logic signed [DATA_W-1:0] out_r;

  // Output registers
  logic signed [DATA_W-1:0] left_out_q, left_out_d;
  logic signed [DATA_W-1:0] right_out_q, right_out_d;
  logic                     out_vld_q, out_vld_d;
  logic                     overrun_q, overrun_d;

  // FSM next state and per-state strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.sample_vld) begin
          accept  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        rd_en   = 1'b1;
        state_d = S_MUL;
      end
      S_MUL: begin
        state_d = S_SUM;
      end
      S_SUM: begin
        ram_we  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture inputs and settings so mid-flight changes only affect the next sample.
  always_comb begin
    lin_d  = lin_q;
    rin_d  = rin_q;
    dlen_d = dlen_q;
    fbg_d  = fbg_q;
    mixg_d = mixg_q;
    mode_d = mode_q;
    if (accept) begin
      lin_d  = io.left_in;
      rin_d  = io.right_in;
      // A zero-length delay would read the slot about to be written; use 1.
      dlen_d = (io.delay_len == '0) ? ADDR_W'(1) : io.delay_len;
      fbg_d  = io.fb_gain;
      mixg_d = io.mix_gain;
      mode_d = io.mode;
    end
  end

  // Read address trails the write pointer by the delay, wrapping naturally.
  assign rd_addr = wr_ptr_q - dlen_q;

  // Buffer storage: written in SUM, read in RD; contents are never reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_l[wr_ptr_q] <= wr_l;
      mem_r[wr_ptr_q] <= wr_r;
    end
    if (rd_en) begin
      rd_l_q <= mem_l[rd_addr];
      rd_r_q <= mem_r[rd_addr];
    end
  end

  // Gate taps until enough history exists, then form feedback and wet products.
  always_comb begin
    tap_ok  = (fill_cnt_q >= dlen_q);
    tap_l   = tap_ok ? rd_l_q : '0;
    tap_r   = tap_ok ? rd_r_q : '0;
    fb_l_d  = fb_l_q;
    fb_r_d  = fb_r_q;
    wet_l_d = wet_l_q;
    wet_r_d = wet_r_q;
    if (state_q == S_MUL) begin
      fb_l_d  = scale(tap_l, fbg_q);
      fb_r_d  = scale(tap_r, fbg_q);
      wet_l_d = scale(tap_l, mixg_q);
      wet_r_d = scale(tap_r, mixg_q);
    end
  end

  // Routing and saturation for the values written back and played out.
  always_comb begin
    mono_sum = (FW'(lin_q) + FW'(rin_q)) >>> 1;
    dry_l    = lin_q;
    dry_r    = rin_q;
    if (mode_q == MODE_MONO) begin
      dry_l = DATA_W'(mono_sum);
      dry_r = DATA_W'(mono_sum);
    end
    wr_l  = sat(SW'(dry_l) + SW'(fb_l_q));
    wr_r  = sat(SW'(dry_r) + SW'(fb_r_q));
    out_l = sat(SW'(dry_l) + SW'(wet_l_q));
    out_r = sat(SW'(dry_r) + SW'(wet_r_q));
    case (mode_q)
      MODE_PING: begin
        // Cross-coupled lines: each buffer is fed by the other's tap.
        wr_l = sat(SW'(dry_l) + SW'(fb_r_q));
        wr_r = sat(SW'(fb_l_q));
      end
      MODE_BYP: begin
        // Keep the buffers recording dry audio so leaving bypass is seamless.
        wr_l  = lin_q;
        wr_r  = rin_q;
        out_l = lin_q;
        out_r = rin_q;
      end
      MODE_STEREO: begin
        wr_l = sat(SW'(dry_l) + SW'(fb_l_q));
        wr_r = sat(SW'(dry_r) + SW'(fb_r_q));
      end
      default: begin
        wr_l = sat(SW'(dry_l) + SW'(fb_l_q));
        wr_r = sat(SW'(dry_r) + SW'(fb_r_q));
      end
    endcase
  end

  // Commit results and advance the buffer pointers at the end of SUM.
  always_comb begin
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    out_vld_d   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    if (ram_we) begin
      left_out_d  = out_l;
      right_out_d = out_r;
      out_vld_d   = 1'b1;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      fill_cnt_d  = (fill_cnt_q == {ADDR_W{1'b1}}) ? fill_cnt_q
                                                    : fill_cnt_q + ADDR_W'(1);
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    drop      = io.sample_vld && (state_q != S_IDLE);
    overrun_d = drop | (overrun_q & ~io.overrun_clr);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lin_q       <= '0;
      rin_q       <= '0;
      dlen_q      <= '0;
      fbg_q       <= '0;
      mixg_q      <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      fb_l_q      <= '0;
      fb_r_q      <= '0;
      wet_l_q     <= '0;
      wet_r_q     <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      out_vld_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lin_q       <= lin_d;
      rin_q       <= rin_d;
      dlen_q      <= dlen_d;
      fbg_q       <= fbg_d;
      mixg_q      <= mixg_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      fb_l_q      <= fb_l_d;
      fb_r_q      <= fb_r_d;
      wet_l_q     <= wet_l_d;
      wet_r_q     <= wet_r_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      out_vld_q   <= out_vld_d;
      overrun_q   <= overrun_d;
    end
  end

  assign io.left_out  = left_out_q;
  assign io.right_out = right_out_q;
  assign io.out_vld   = out_vld_q;
  assign io.busy      = (state_q != S_IDLE);
  assign io.overrun   = overrun_q;
  assign io.dbg_state = state_q;

endmodule

// File: tb/tb_delay_fb_core.sv
// Directed bench for delay_fb_core with a small buffer (16 entries).
module tb_delay_fb_core;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int COEF_W = 8;

  typedef logic signed [31:0] word_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_fb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) bus ();

  delay_fb_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // Scoreboard
  logic signed [DATA_W-1:0] exp_l_q[$];
  logic signed [DATA_W-1:0] exp_r_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_cfg(input int dl, input int fb, input int mx, input int md);
    bus.delay_len = ADDR_W'(dl);
    bus.fb_gain   = COEF_W'(fb);
    bus.mix_gain  = COEF_W'(mx);
    bus.mode      = 2'(md);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_vld  = 1'b0;
    bus.overrun_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_l_q.delete();
    exp_r_q.delete();
  endtask

  // Drive one sample, wait for its result, compare latency, busy and data.
  task automatic send(input string tag, input int l, input int r, input int el, input int er);
    int lat;
    bit seen;
    bit busy_ok;
    logic signed [DATA_W-1:0] xl;
    logic signed [DATA_W-1:0] xr;
    exp_l_q.push_back(DATA_W'(el));
    exp_r_q.push_back(DATA_W'(er));
    bus.left_in    = DATA_W'(l);
    bus.right_in   = DATA_W'(r);
    bus.sample_vld = 1'b1;
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 12) begin
      @(negedge clk);
      bus.sample_vld = 1'b0;
      lat++;
      if (bus.out_vld) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_busy"}, word_t'(busy_ok & ~bus.busy), 1);
    xl = exp_l_q.pop_front();
    xr = exp_r_q.pop_front();
    check({tag, "_L"}, word_t'(bus.left_out), word_t'(xl));
    check({tag, "_R"}, word_t'(bus.right_out), word_t'(xr));
  endtask

  // Stimulus tables
  int imp_l[8]  = '{1000, 0, 0, 0, 0, 0, 0, 0};
  int imp_r[8]  = '{0, -2000, 0, 0, 0, 0, 0, 0};
  int imp_el[8] = '{1000, 0, 0, 500, 0, 0, 0, 0};
  int imp_er[8] = '{0, -2000, 0, 0, -1000, 0, 0, 0};
  int fbk_el[10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};
  int pp_el[5] = '{1000, 0, 996, 0, 0};
  int pp_er[5] = '{0, 0, 0, 0, 498};

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int nv;
    word_t cap;

    rst             = 1'b1;
    bus.sample_vld  = 1'b0;
    bus.left_in     = '0;
    bus.right_in    = '0;
    bus.overrun_clr = 1'b0;
    set_cfg(1, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_left_out", word_t'(bus.left_out), 0);
    check("rst_right_out", word_t'(bus.right_out), 0);
    check("rst_out_vld", word_t'(bus.out_vld), 0);
    check("rst_busy", word_t'(bus.busy), 0);
    check("rst_overrun", word_t'(bus.overrun), 0);
    check("rst_state", word_t'(bus.dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse, stereo, no feedback
    set_cfg(3, 0, 128, 0);
    for (int i = 0; i < 8; i++)
      send($sformatf("imp%0d", i), imp_l[i], imp_r[i], imp_el[i], imp_er[i]);

    // Feedback decay
    do_reset();
    set_cfg(3, 128, 128, 0);
    for (int i = 0; i < 10; i++)
      send($sformatf("fbk%0d", i), (i == 0) ? 1000 : 0, 0, fbk_el[i], 0);

    // Bypass fills the whole buffer with non-zero dry audio
    set_cfg(1, 0, 255, 3);
    for (int i = 0; i < 16; i++)
      send($sformatf("byp%0d", i), 5000, -5000, 5000, -5000);

    // Reset in the middle of SUM
    bus.left_in    = 16'sd7;
    bus.right_in   = 16'sd7;
    bus.sample_vld = 1'b1;
    @(negedge clk);
    bus.sample_vld = 1'b0;
    guard = 0;
    while (bus.dbg_state != 2'd3 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reach_sum", word_t'(bus.dbg_state), 3);
    rst = 1'b1;
    #1;
    check("mid_left_out", word_t'(bus.left_out), 0);
    check("mid_right_out", word_t'(bus.right_out), 0);
    check("mid_busy", word_t'(bus.busy), 0);
    check("mid_state", word_t'(bus.dbg_state), 0);
    @(negedge clk);
    check("mid_out_vld", word_t'(bus.out_vld), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_out_vld2", word_t'(bus.out_vld), 0);
    check("mid_overrun", word_t'(bus.overrun), 0);
    // Stale RAM (5000) must not be heard on the first tap after reset
    set_cfg(1, 0, 255, 0);
    send("post0", 100, -100, 100, -100);
    send("post1", 0, 0, 99, -100);

    // Mono-sum with delay_len 0 acting as 1
    do_reset();
    set_cfg(0, 0, 128, 1);
    send("mono0", 1000, 3000, 2000, 2000);
    send("mono1", 0, 0, 1000, 1000);
    send("mono2", -3, 0, -2, -2);

    // Longest delay; write and read pointers both wrap
    do_reset();
    set_cfg(15, 0, 128, 0);
    for (int k = 0; k < 17; k++) begin
      int l;
      int r;
      int el;
      int er;
      l  = (k == 0) ? 800 : (k == 1) ? 600 : 0;
      r  = (k == 1) ? -400 : 0;
      el = (k == 15) ? 400 : (k == 16) ? 300 : l;
      er = (k == 16) ? -200 : r;
      send($sformatf("wrap%0d", k), l, r, el, er);
    end

    // Positive saturation; the last step reads back the clamped RAM word
    do_reset();
    set_cfg(1, 255, 255, 0);
    send("satp0", 30000, 0, 30000, 0);
    send("satp1", 30000, 0, 32767, 0);
    send("satp2", 30000, 0, 32767, 0);
    send("satp3", 0, 0, 32639, 0);

    // Negative saturation
    do_reset();
    set_cfg(1, 255, 255, 0);
    send("satn0", -30000, 0, -30000, 0);
    send("satn1", -30000, 0, -32768, 0);
    send("satn2", -30000, 0, -32768, 0);
    send("satn3", 0, 0, -32640, 0);

    // Overrun: second strobe two cycles later is dropped
    do_reset();
    set_cfg(1, 0, 0, 0);
    bus.left_in    = 16'sd11;
    bus.right_in   = 16'sd22;
    bus.sample_vld = 1'b1;
    @(negedge clk);
    bus.sample_vld = 1'b0;
    @(negedge clk);
    bus.left_in    = 16'sd99;
    bus.sample_vld = 1'b1;
    @(negedge clk);
    bus.sample_vld = 1'b0;
    check("ovr_set", word_t'(bus.overrun), 1);
    nv  = 0;
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_vld) begin
        nv++;
        cap = word_t'(bus.left_out);
      end
    end
    check("ovr_one_out", nv, 1);
    check("ovr_out_val", cap, 11);
    check("ovr_sticky", word_t'(bus.overrun), 1);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("ovr_cleared", word_t'(bus.overrun), 0);
    // Set and clear in the same cycle: set wins
    bus.sample_vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_set2", word_t'(bus.overrun), 1);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    check("ovr_set_wins", word_t'(bus.overrun), 1);
    bus.sample_vld = 1'b0;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("ovr_clr_alone", word_t'(bus.overrun), 0);
    repeat (6) @(negedge clk);

    // Ping-pong, then bypass mid-stream, then back to ping-pong
    do_reset();
    set_cfg(2, 128, 255, 2);
    for (int i = 0; i < 5; i++)
      send($sformatf("pp%0d", i), (i == 0) ? 1000 : 0, 0, pp_el[i], pp_er[i]);
    set_cfg(2, 128, 255, 3);
    send("ppbyp0", 1234, -4321, 1234, -4321);
    send("ppbyp1", 7, 8, 7, 8);
    set_cfg(2, 128, 255, 2);
    send("ppback", 0, 0, 1229, -4305);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_fb_core.md
Name: delay_fb_core

Overview:
Parametrised stereo digital delay with feedback, wet/dry mix, saturation and selectable routing modes. It sits between the codec receive path and the output mixer and processes one stereo sample per sample_vld strobe. Each channel has an internal circular buffer, and the delay length is runtime-programmable up to the buffer depth. It is a successor to the fixed-length mono-sum delay: it adds variable delay, feedback, mix, per-channel lines, modes and overrun detection.

Parameters:
DATA_W, 16, signed two's-complement sample width
ADDR_W, 15, buffer address width; DEPTH = 2**ADDR_W entries per channel
COEF_W, 8, unsigned gain width; gain = value / 2**COEF_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sample_vld  in  1  one-cycle strobe; left_in/right_in valid
left_in  in  DATA_W  signed left sample
right_in  in  DATA_W  signed right sample
delay_len  in  ADDR_W  delay in samples; 0 is treated as 1
fb_gain  in  COEF_W  feedback gain
mix_gain  in  COEF_W  wet gain
mode  in  2  00 stereo, 01 mono-sum, 10 ping-pong, 11 bypass
overrun_clr  in  1  clears overrun
left_out  out  DATA_W  signed left result
right_out  out  DATA_W  signed right result
out_vld  out  1  one-cycle strobe; outputs updated
busy  out  1  high while a sample is in flight
overrun  out  1  sticky; a sample_vld was dropped

Behaviour:
- Reset is asynchronous and active-high. On reset: left_out=0, right_out=0, out_vld=0, busy=0, overrun=0, wr_ptr=0, fill_cnt=0, FSM=IDLE. RAM contents are not reset.
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- FSM states: IDLE, RD, MUL, SUM.
  - IDLE->RD: sample_vld=1. Latches inputs, delay_len (0 becomes 1), fb_gain, mix_gain and mode. Later changes to these inputs apply only to the next accepted sample.
  - RD->MUL: issues rd_addr = (wr_ptr - delay_len) mod DEPTH. The RAM has 1-cycle registered read.
  - MUL->SUM: registers the taps and the products tap*fb_gain and tap*mix_gain, each arithmetic-shifted right by COEF_W.
  - SUM->IDLE: writes both RAMs at wr_ptr, registers the outputs, sets out_vld=1 for the next cycle, wr_ptr+=1 (wraps DEPTH-1->0), fill_cnt+=1 (saturates at DEPTH-1).
- Latency: sample_vld high in cycle n gives out_vld high in cycle n+4. busy is high in cycles n+1..n+3.
- Acceptance: sample_vld is accepted only in IDLE. If sample_vld is high while busy=1, the sample is dropped and overrun is set. overrun_clr clears overrun; if a set and a clear occur in the same cycle, set wins.
- Tap validity: a tap is used only if fill_cnt >= delay_len; otherwise the tap is 0. This prevents stale RAM contents from being played out after reset or after delay_len is increased.
- Arithmetic: all sums are computed at DATA_W+2 bits and then saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - dry_L/dry_R = inputs. In mono-sum mode, dry_L = dry_R = (left_in+right_in)>>>1.
  - stereo / mono-sum: wr_L = sat(dry_L + fbL), wr_R = sat(dry_R + fbR).
  - ping-pong: wr_L = sat(dry_L + fbR), wr_R = sat(fbL); each buffer feeds the other.
  - out_X = sat(dry_X + wetX), where fbX and wetX are the scaled products for that channel's tap.
  - bypass: out = dry inputs unmodified. RAM is written with dry and fill_cnt advances, so leaving bypass produces no glitch.
- Boundaries:
  - delay_len > fill_cnt mid-stream: taps read as 0 until the buffer fills.
  - delay_len = DEPTH-1: valid; rd_addr wraps.
  - Reset mid-operation: FSM returns to IDLE, no out_vld, the in-flight sample is lost and fill_cnt=0.

Test Plan:
1. Reset: assert rst mid-SUM -> outputs=0, out_vld=0, busy=0, overrun=0. After release, the first tap reads 0 despite stale RAM.
2. Impulse (ADDR_W=4, delay_len=3, fb=0, mix=128, stereo): L=1000 then zeros -> left_out sequence 1000,0,0,500,0,0...; out_vld in cycle n+4 of each strobe.
3. Feedback (delay_len=3, fb=128, mix=128): L impulse 1000 -> left_out 1000,0,0,500,0,0,250,0,0,125.
4. Saturation (delay_len=1, fb=255, mix=255): L held at 30000 -> left_out clamps at 32767; RAM writes clamp at 32767; no wrap to negative. Repeat with -30000 -> clamps at -32768.
5. Overrun: sample_vld in cycles n and n+2 -> second sample dropped, one out_vld only, overrun=1. It stays 1 until overrun_clr, and stays 1 if a new drop coincides with overrun_clr.
6. Ping-pong (delay_len=2, fb=128, mix=255): L impulse 1000, R=0 -> right tap feeds left. left_out at samples 0 and 2 is 1000 and 996. right_out at sample 4 is 498. Switching to mode 11 mid-stream gives out = in with no transient.
